demultiplexer_sync: RTL and testbench
=====================================

DEMULTIPLEXER_SYNC -- requirements
Module: demultiplexer_sync

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, giving the data width of the input and of each output channel.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port in_data, input, WIDTH bits: the word to route.
REQ-005 The block SHALL have port in_sel, input, 2 bits: the destination channel (00=A, 01=B, 10=C, 11=D).
REQ-006 The block SHALL have port in_valid, input, 1 bit: in_data/in_sel are valid.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts the word this cycle.
REQ-008 The block SHALL have ports out_data_a, out_data_b, out_data_c, out_data_d, each output, WIDTH bits: per-channel data.
REQ-009 The block SHALL have port out_valid, output, 4 bits: per-channel valid; bit 0=A ... bit 3=D.
REQ-010 The block SHALL have port out_ready, input, 4 bits: per-channel consumer ready; same bit order as out_valid.
REQ-011 The block SHALL have port acc_count, output, 8 bits: count of accepted input words.

Function
REQ-012 Each channel SHALL hold a one-entry buffer (data register plus full flag); out_valid[i] SHALL equal the full flag of channel i.
REQ-013 in_ready SHALL be combinational: 1 when the buffer of channel in_sel is empty or out_ready[in_sel] is 1; 0 otherwise.
REQ-014 A word SHALL be accepted when in_valid and in_ready are both 1 on a rising clk edge.
REQ-015 On acceptance, in_data SHALL load the buffer selected by in_sel and set its full flag; out_valid rises exactly one cycle after the accepting edge.
REQ-016 A channel output transfer SHALL occur when out_valid[i] and out_ready[i] are both 1 on a rising edge; the full flag then clears unless the same edge loads that channel.
REQ-017 A simultaneous drain and load of the same channel SHALL leave full set and the buffer holding the new word, with no bubble and no loss.
REQ-018 out_data_x SHALL hold its last loaded value while its out_valid is 0.
REQ-019 A word SHALL never be duplicated, dropped, or delivered to any channel other than in_sel at acceptance.
REQ-020 Channels SHALL be independent: a stalled channel SHALL not block acceptance for another channel.
REQ-021 When in_valid is 0, in_sel and in_data SHALL have no effect on state.
REQ-022 acc_count SHALL increment by 1 per acceptance and wrap from 255 to 0.

Reset
REQ-023 While rst_n is 0, all full flags, all data registers and acc_count SHALL be 0, and in_ready SHALL be forced to 0.
REQ-024 Reset asserted mid-operation SHALL immediately discard all buffered words; out_valid SHALL go to 4'b0000 without waiting for clk.
REQ-025 On the first edge after rst_n deasserts, in_ready SHALL be 1 for any in_sel.

Structure
REQ-026 Package demux_pkg SHALL define the channel count NCH=4, the channel index constants CH_A..CH_D (2'b00..2'b11) and the default WIDTH.
REQ-027 The one-entry buffer SHALL be a sub-module demux_slot, instantiated four times; acc_count and in_ready logic SHALL live in the top module.

Verification
REQ-028 The bench SHALL send sel=00,data=01 then sel=11,data=10 with all out_ready=1 -> out_valid[0] high with A=01 one cycle after the first accept, and out_valid[3] high with D=10 one cycle after the second; acc_count=2.
REQ-029 The bench SHALL hold out_ready[1]=0 and send two words to B -> the first is accepted, in_ready=0 for the second while sel=01, and a word with sel=10 is still accepted.
REQ-030 With B full and out_ready[1]=1, the bench SHALL present sel=01,data=11 -> drain and load on the same edge, out_valid[1] stays 1, B=11, and no cycle has out_valid low.
REQ-031 The bench SHALL send 256 accepted words -> acc_count reads 255 after the 255th and 0 after the 256th.
REQ-032 The bench SHALL fill all four channels, then pulse rst_n low between edges -> out_valid=0000, acc_count=0, in_ready=0 immediately, and in_ready=1 after release.
REQ-033 The bench SHALL run random in_valid/in_sel/out_ready for 10k cycles against a scoreboard -> per-channel in-order delivery, with zero loss and zero misrouting.

Source files
------------

// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants for the four-channel synchronous demultiplexer
package demux_pkg;

    localparam int NCH       = 4;
    localparam int DEF_WIDTH = 2;

    localparam logic [1:0] CH_A = 2'b00;
    localparam logic [1:0] CH_B = 2'b01;
    localparam logic [1:0] CH_C = 2'b10;
    localparam logic [1:0] CH_D = 2'b11;

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output buffer (data register plus full flag)
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic             r_full;
    logic [WIDTH-1:0] r_data;

    // Load wins over drain so a same-edge drain+load keeps the slot full with the new word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_data <= '0;
        end else if (i_load) begin
            r_full <= 1'b1;
            r_data <= i_data;
        end else if (r_full && i_ready) begin
            r_full <= 1'b0;
        end
    end

    assign o_valid = r_full;
    assign o_data  = r_data;

endmodule

// File: rtl/demultiplexer_sync.sv
// rtl/demultiplexer_sync.sv - routes each accepted word into one of four buffered channels
module demultiplexer_sync
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data_a,
    output logic [WIDTH-1:0] out_data_b,
    output logic [WIDTH-1:0] out_data_c,
    output logic [WIDTH-1:0] out_data_d,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [7:0]       acc_count
);

    logic [NCH-1:0]   w_full;
    logic [NCH-1:0]   w_load;
    logic [WIDTH-1:0] w_data [NCH];
    logic             w_accept;
    logic [7:0]       r_acc_count;

    // The selected slot can take a word if empty or if it drains on this same edge;
    // rst_n gates it so nothing is offered during reset.
    assign in_ready = rst_n & (~w_full[in_sel] | out_ready[in_sel]);
    assign w_accept = in_valid & in_ready;

    for (genvar g = 0; g < NCH; g++) begin : g_slot
        localparam logic [1:0] CH_IDX = 2'(g);

        assign w_load[g] = w_accept & (in_sel == CH_IDX);

        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_load  (w_load[g]),
            .i_data  (in_data),
            .i_ready (out_ready[g]),
            .o_valid (w_full[g]),
            .o_data  (w_data[g])
        );
    end

    // Free-running count of accepted words, wraps naturally at 8 bits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_count <= 8'd0;
        end else if (w_accept) begin
            r_acc_count <= r_acc_count + 8'd1;
        end
    end

    assign out_valid  = w_full;
    assign out_data_a = w_data[CH_A];
    assign out_data_b = w_data[CH_B];
    assign out_data_c = w_data[CH_C];
    assign out_data_d = w_data[CH_D];
    assign acc_count  = r_acc_count;

endmodule

// File: tb/tb_demultiplexer_sync.sv
// tb/tb_demultiplexer_sync.sv - directed and random checks of demultiplexer_sync against a queue model
module tb_demultiplexer_sync;

    localparam int W = 2;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] in_data;
    logic [1:0]   in_sel;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data_a;
    logic [W-1:0] out_data_b;
    logic [W-1:0] out_data_c;
    logic [W-1:0] out_data_d;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;
    logic [7:0]   acc_count;

    demultiplexer_sync #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data_a (out_data_a),
        .out_data_b (out_data_b),
        .out_data_c (out_data_c),
        .out_data_d (out_data_d),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .acc_count  (acc_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] od [4];
    assign od[0] = out_data_a;
    assign od[1] = out_data_b;
    assign od[2] = out_data_c;
    assign od[3] = out_data_d;

    typedef logic [W-1:0] word_q_t[$];
    word_q_t      q [4];
    logic [W-1:0] last [4];
    int           acc_m;
    int           total;
    int           bad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 4; c++) begin
            q[c].delete();
            last[c] = '0;
        end
        acc_m = 0;
    endtask

    // One clock: check outputs mid-cycle, advance the model, land at posedge+1
    task automatic tick();
        logic exp_rdy;
        @(negedge clk);
        exp_rdy = rst_n && (q[in_sel].size() == 0 || out_ready[in_sel]);
        chk("in_ready", in_ready, exp_rdy);
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("out_valid[%0d]", c), out_valid[c], q[c].size() != 0);
            chk($sformatf("out_data[%0d]", c), od[c], last[c]);
        end
        chk("acc_count", acc_count, acc_m[7:0]);
        for (int c = 0; c < 4; c++)
            if (q[c].size() != 0 && out_ready[c]) void'(q[c].pop_front());
        if (in_valid && exp_rdy) begin
            q[in_sel].push_back(in_data);
            last[in_sel] = in_data;
            acc_m = (acc_m + 1) % 256;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] s, input logic [W-1:0] d);
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        tick();
    endtask

    // Reset pulsed between edges; outputs must clear without a clock
    task automatic pulse_reset();
        in_valid = 1'b1;
        rst_n    = 1'b0;
        #1;
        chk("rst out_valid", out_valid, 4'b0000);
        chk("rst acc_count", acc_count, 8'd0);
        chk("rst in_ready", in_ready, 1'b0);
        for (int c = 0; c < 4; c++)
            chk($sformatf("rst out_data[%0d]", c), od[c], '0);
        rst_n = 1'b1;
        #1;
        chk("post-rst in_ready", in_ready, 1'b1);
        in_valid = 1'b0;
        model_clear();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_sel    = 2'b00;
        in_data   = '0;
        out_ready = 4'b0000;
        model_clear();

        repeat (2) @(posedge clk);
        #1;
        chk("init out_valid", out_valid, 4'b0000);
        chk("init acc_count", acc_count, 8'd0);
        chk("init in_ready", in_ready, 1'b0);
        rst_n = 1'b1;
        #1;
        chk("init ready after release", in_ready, 1'b1);
        @(posedge clk);
        #1;

        // Two words to A then D with all consumers ready
        out_ready = 4'b1111;
        send(2'b00, 2'b01);
        chk("A valid", out_valid[0], 1'b1);
        chk("A data", out_data_a, 2'b01);
        send(2'b11, 2'b10);
        chk("D valid", out_valid[3], 1'b1);
        chk("D data", out_data_d, 2'b10);
        chk("A drained", out_valid[0], 1'b0);
        chk("acc after 2", acc_count, 8'd2);
        in_valid = 1'b0;
        tick();

        // Stalled B blocks only B
        out_ready = 4'b1101;
        send(2'b01, 2'b10);
        chk("B held", out_valid[1], 1'b1);
        in_valid = 1'b1;
        in_sel   = 2'b01;
        in_data  = 2'b11;
        #1;
        chk("B stalled ready", in_ready, 1'b0);
        tick();
        in_sel  = 2'b10;
        in_data = 2'b01;
        #1;
        chk("C ready while B stalled", in_ready, 1'b1);
        tick();
        chk("B still 10", out_data_b, 2'b10);

        // Drain and load B on the same edge
        out_ready = 4'b1111;
        in_sel    = 2'b01;
        in_data   = 2'b11;
        #1;
        chk("B pre-swap valid", out_valid[1], 1'b1);
        chk("B swap ready", in_ready, 1'b1);
        tick();
        chk("B swap valid", out_valid[1], 1'b1);
        chk("B swap data", out_data_b, 2'b11);
        in_valid = 1'b0;
        tick();

        // Fill all channels then reset mid-operation
        out_ready = 4'b0000;
        for (int c = 0; c < 4; c++) send(2'(c), 2'(c));
        chk("all full", out_valid, 4'b1111);
        pulse_reset();

        // Counter wrap over 256 acceptances
        out_ready = 4'b1111;
        for (int n = 1; n <= 256; n++) begin
            send(2'($urandom_range(0, 3)), 2'($urandom));
            if (n == 255) chk("acc at 255", acc_count, 8'd255);
            if (n == 256) chk("acc wrap", acc_count, 8'd0);
        end
        in_valid = 1'b0;
        tick();

        // Random traffic against the queue model
        for (int n = 0; n < 10000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = 2'($urandom);
            out_ready = 4'($urandom);
            tick();
        end

        // Drain everything and confirm nothing is left or lost
        in_valid  = 1'b0;
        out_ready = 4'b1111;
        repeat (3) tick();
        chk("final empty", out_valid, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
